// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Program counter with an integrated return-address stack.
//               One command per cycle, priority clr > ret > call > load >
//               inc > hold. call pushes out+1 and jumps to in; ret pops the
//               most recent return address into the PC. Overflow (call when
//               full) and underflow (ret when empty) are suppressed: no push,
//               no pop, no jump, and the PC holds.
//
//               Optional feature macro: PC_STACK_ERR_EN
//                 defined   -> err is a sticky register set on overflow or
//                              underflow, cleared only by rst_n or clr.
//                 undefined -> err is tied to 0 and no err register exists.
//
// Parameters  : WIDTH  address width in bits (>= 2)
//               DEPTH  number of return-stack entries (>= 2)
//
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               clr    synchronous clear (PC, depth, err)
//               ret    pop the return address into the PC
//               call   push out+1, then jump to in
//               load   jump to in
//               inc    advance the PC by 1 (wraps)
//               in     jump/call target
//               out    current PC
//               depth  number of occupied stack entries
//               full   depth == DEPTH
//               empty  depth == 0
//               err    sticky overflow/underflow flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       ret,
    input  logic                       call,
    input  logic                       load,
    input  logic                       inc,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int               c_DW    = $clog2(DEPTH+1);
    localparam logic [c_DW-1:0]  c_FULL  = c_DW'(DEPTH);
    localparam logic [c_DW-1:0]  c_DONE  = c_DW'(1);
    localparam logic [WIDTH-1:0] c_WONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_pc;
    logic [c_DW-1:0]  r_depth;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_fault;

    assign w_pc_inc = r_pc + c_WONE;
    assign w_full   = (r_depth == c_FULL);
    assign w_empty  = (r_depth == '0);

    // Decode the winning command into stack actions. A faulting ret/call
    // still wins priority, so lower strobes stay ignored in that cycle.
    always_comb begin
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_fault = 1'b0;
        if (!clr) begin
            if (ret) begin
                w_pop   = !w_empty;
                w_fault = w_empty;
            end else if (call) begin
                w_push  = !w_full;
                w_fault = w_full;
            end
        end
    end

    // Top-of-stack read: the entry just below the depth pointer.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_depth == c_DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_depth <= '0;
        end else if (clr) begin
            r_pc    <= '0;
            r_depth <= '0;
        end else if (ret) begin
            if (w_pop) begin
                r_pc    <= w_top;
                r_depth <= r_depth - c_DONE;
            end
        end else if (call) begin
            if (w_push) begin
                r_pc    <= in;
                r_depth <= r_depth + c_DONE;
            end
        end else if (load) begin
            r_pc <= in;
        end else if (inc) begin
            r_pc <= w_pc_inc;
        end
    end

    // Stack storage needs no reset: entries at or above depth are never
    // observable, and depth itself is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_depth == c_DW'(i))) begin
                r_stack[i] <= w_pc_inc;
            end
        end
    end

`ifdef PC_STACK_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (clr) begin
            r_err <= 1'b0;
        end else if (w_fault) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_fault_unused;
    assign w_fault_unused = w_fault;
    assign err            = 1'b0;
`endif

    assign out   = r_pc;
    assign depth = r_depth;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack
// Description : Self-checking bench for pc_stack (WIDTH=16, DEPTH=8). A
//               queue-based model tracks the PC and return stack; a compare
//               process checks every DUT output against it on each falling
//               edge, and directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH+1);
`ifdef PC_STACK_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             clr, ret, call, load, inc;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             full, empty, err;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    int unsigned m_pc;
    int unsigned m_stk[$];
    bit          m_err;

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .ret   (ret),
        .call  (call),
        .load  (load),
        .inc   (inc),
        .in    (in),
        .out   (out),
        .depth (depth),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
    endfunction

    // Apply the specification's priority rules to the model.
    function automatic void model_step(bit c_clr, bit c_ret, bit c_call, bit c_load,
                                       bit c_inc, int unsigned c_in);
        int unsigned mask = (1 << WIDTH) - 1;
        if (c_clr) begin
            model_reset();
        end else if (c_ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = m_err | ERR_ON;
        end else if (c_call) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_pc + 1) & mask);
                m_pc = c_in & mask;
            end else begin
                m_err = m_err | ERR_ON;
            end
        end else if (c_load) begin
            m_pc = c_in & mask;
        end else if (c_inc) begin
            m_pc = (m_pc + 1) & mask;
        end
    endfunction

    // One command cycle: drive after the falling edge, update the model on
    // the rising edge, then drop the strobes so idle cycles are holds.
    task automatic step(input bit c_clr, input bit c_ret, input bit c_call,
                        input bit c_load, input bit c_inc, input int unsigned c_in);
        @(negedge clk);
        clr = c_clr; ret = c_ret; call = c_call; load = c_load; inc = c_inc;
        in  = WIDTH'(c_in);
        @(posedge clk);
        model_step(c_clr, c_ret, c_call, c_load, c_inc, c_in);
        #1;
        clr = 0; ret = 0; call = 0; load = 0; inc = 0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out",   out,   0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_err",   err,   0);
        chk("rst_depth", depth, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Per-cycle compare against the model.
    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_out",   out,   m_pc);
            chk("cyc_depth", depth, m_stk.size());
            chk("cyc_full",  full,  (m_stk.size() == DEPTH) ? 1 : 0);
            chk("cyc_empty", empty, (m_stk.size() == 0) ? 1 : 0);
            chk("cyc_err",   err,   m_err);
        end
    end

    initial begin
        rst_n = 1'b1;
        clr = 0; ret = 0; call = 0; load = 0; inc = 0; in = '0;
        model_reset();
        async_reset();
        cmp_on = 1'b1;

        // Reset and increment, then wrap at the top of the address space.
        repeat (3) step(0, 0, 0, 0, 1, 0);
        chk("inc3", out, 3);
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 0, 0, 1, 0);
        chk("wrap", out, 0);

        // Call / return
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0100);
        chk("call_out", out, 16'h0100);
        chk("call_depth", depth, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("ret_out", out, 16'h0011);
        chk("ret_empty", empty, 1);

        // Back-to-back call then ret returns to pre-call out+1
        step(0, 0, 1, 0, 0, 16'h0300);
        step(0, 1, 0, 0, 0, 0);
        chk("b2b_ret", out, 16'h0012);

        // Nesting to full, then overflow, then unwind in LIFO order
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0, 16'h1000 + i);
        chk("nest_full", full, 1);
        chk("nest_depth", depth, 8);
        chk("nest_err0", err, 0);
        step(0, 0, 1, 0, 0, 16'h2000);
        chk("ovf_out", out, 16'h1007);
        chk("ovf_depth", depth, 8);
        chk("ovf_err", err, ERR_ON);
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("lifo", out, (k < 7) ? (16'h1007 - k) : 1);
        end
        chk("lifo_empty", empty, 1);

        // Underflow from reset, then clr clears err
        async_reset();
        step(0, 1, 0, 0, 0, 0);
        chk("unf_out", out, 0);
        chk("unf_depth", depth, 0);
        chk("unf_err", err, ERR_ON);
        step(0, 0, 0, 0, 1, 0);
        chk("err_sticky", err, ERR_ON);
        step(1, 0, 0, 0, 0, 0);
        chk("clr_err", err, 0);

        // Priority
        step(0, 0, 0, 1, 0, 16'h001F);
        step(0, 0, 1, 0, 0, 16'h0004);
        step(0, 0, 0, 0, 1, 0);
        chk("pri_setup", out, 5);
        step(0, 1, 1, 0, 1, 16'h0040);
        chk("pri_ret_out", out, 16'h0020);
        chk("pri_ret_depth", depth, 0);
        step(0, 0, 0, 1, 1, 16'h0040);
        chk("pri_load", out, 16'h0040);
        step(0, 0, 1, 1, 1, 16'h0050);
        chk("pri_call", out, 16'h0050);
        step(1, 1, 1, 1, 1, 16'h0060);
        chk("pri_clr", out, 0);
        chk("pri_clr_depth", depth, 0);

        // Reset mid-operation discards the stack
        step(0, 0, 1, 0, 0, 16'h0077);
        async_reset();
        chk("midrst_depth", depth, 0);
        repeat (2) @(negedge clk);

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
